// File: rtl/pzcorebus_outstanding_limiter_if.sv
// Request/response bus bundle: command, write-data and response channels with valid/accept handshakes.
// No storage and no latency; backpressure is carried by scmd_accept, sdata_accept and mresp_accept.
interface pzcorebus_if #(
    parameter int ID_WIDTH     = 4,
    parameter int ADDR_WIDTH   = 16,
    parameter int LENGTH_WIDTH = 4,
    parameter int INFO_WIDTH   = 2,
    parameter int DATA_WIDTH   = 32
);
    logic                      mcmd_valid;
    logic                      scmd_accept;
    logic [2:0]                mcmd;
    logic [ID_WIDTH-1:0]       mid;
    logic [ADDR_WIDTH-1:0]     maddr;
    logic [LENGTH_WIDTH-1:0]   mlength;
    logic [INFO_WIDTH-1:0]     minfo;
    logic                      mdata_valid;
    logic                      sdata_accept;
    logic [DATA_WIDTH-1:0]     mdata;
    logic [DATA_WIDTH/8-1:0]   mdata_byteen;
    logic                      mdata_last;
    logic                      sresp_valid;
    logic                      mresp_accept;
    logic [1:0]                sresp;
    logic [ID_WIDTH-1:0]       sid;
    logic                      serror;
    logic [DATA_WIDTH-1:0]     sdata;
    logic [INFO_WIDTH-1:0]     sinfo;
    logic [1:0]                sresp_last;

    modport master (
        output mcmd_valid, mcmd, mid, maddr, mlength, minfo,
               mdata_valid, mdata, mdata_byteen, mdata_last, mresp_accept,
        input  scmd_accept, sdata_accept,
               sresp_valid, sresp, sid, serror, sdata, sinfo, sresp_last
    );

    modport slave (
        input  mcmd_valid, mcmd, mid, maddr, mlength, minfo,
               mdata_valid, mdata, mdata_byteen, mdata_last, mresp_accept,
        output scmd_accept, sdata_accept,
               sresp_valid, sresp, sid, serror, sdata, sinfo, sresp_last
    );
endinterface

// File: rtl/pzcorebus_outstanding_limiter.sv
// Pass-through stage that caps in-flight non-posted requests and supports a drain/quiesce handshake.
// Zero latency; command channel is held off at MAX_OUTSTANDING or while i_drain, data/response untouched.
module pzcorebus_outstanding_limiter #(
    parameter int BUS_CONFIG      = 0,  // bit 0 set: memory profile (sresp_last[0] marks the final beat)
    parameter int MAX_OUTSTANDING = 8,
    parameter int COUNTER_WIDTH   = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_drain,
    output logic                     o_idle,
    output logic [COUNTER_WIDTH-1:0] o_outstanding,
    output logic                     o_underflow,
    pzcorebus_if.slave               slave_if,
    pzcorebus_if.master              master_if
);
    localparam logic [2:0] CMD_READ             = 3'd1;
    localparam logic [2:0] CMD_WRITE_NON_POSTED = 3'd3;
    localparam logic [2:0] CMD_ATOMIC           = 3'd5;
    localparam logic [COUNTER_WIDTH-1:0] MAX_COUNT = COUNTER_WIDTH'(MAX_OUTSTANDING);
    localparam bit MEMORY_PROFILE = (BUS_CONFIG % 2) != 0;

    function automatic logic is_non_posted_command(input logic [2:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE_NON_POSTED) || (cmd == CMD_ATOMIC);
    endfunction

    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic                     underflow_q, underflow_d;
    logic                     non_posted, block, cmd_hs, resp_final, resp_hs;

    // block depends only on the registered count and i_drain, never on the response channel
    always_comb begin
        non_posted  = is_non_posted_command(slave_if.mcmd);
        block       = i_drain | (non_posted & (count_q == MAX_COUNT));
        cmd_hs      = slave_if.mcmd_valid & master_if.scmd_accept & ~block & non_posted;
        resp_final  = MEMORY_PROFILE ? master_if.sresp_last[0] : 1'b1;
        resp_hs     = master_if.sresp_valid & slave_if.mresp_accept & resp_final;
        count_d     = count_q;
        underflow_d = underflow_q;
        if (cmd_hs && !resp_hs) begin
            count_d = count_q + COUNTER_WIDTH'(1);
        end else if (resp_hs && !cmd_hs) begin
            if (count_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                count_d = count_q - COUNTER_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_outstanding = count_q;
    assign o_underflow   = underflow_q;
    assign o_idle        = (count_q == '0) & ~cmd_hs;

    assign master_if.mcmd_valid   = slave_if.mcmd_valid & ~block;
    assign slave_if.scmd_accept   = master_if.scmd_accept & ~block;
    assign master_if.mcmd         = slave_if.mcmd;
    assign master_if.mid          = slave_if.mid;
    assign master_if.maddr        = slave_if.maddr;
    assign master_if.mlength      = slave_if.mlength;
    assign master_if.minfo        = slave_if.minfo;

    assign master_if.mdata_valid  = slave_if.mdata_valid;
    assign slave_if.sdata_accept  = master_if.sdata_accept;
    assign master_if.mdata        = slave_if.mdata;
    assign master_if.mdata_byteen = slave_if.mdata_byteen;
    assign master_if.mdata_last   = slave_if.mdata_last;

    assign slave_if.sresp_valid   = master_if.sresp_valid;
    assign master_if.mresp_accept = slave_if.mresp_accept;
    assign slave_if.sresp         = master_if.sresp;
    assign slave_if.sid           = master_if.sid;
    assign slave_if.serror        = master_if.serror;
    assign slave_if.sdata         = master_if.sdata;
    assign slave_if.sinfo         = master_if.sinfo;
    assign slave_if.sresp_last    = master_if.sresp_last;
endmodule

// File: doc/pzcorebus_outstanding_limiter.md
Name: pzcorebus_outstanding_limiter

Overview:
- Request/response pass-through stage placed directly downstream of one master port of pzcorebus_1_to_m_switch, in front of the target slave.
- Counts non-posted requests whose final response has not yet returned, and holds off new non-posted commands once MAX_OUTSTANDING is reached.
- Supports a drain handshake so software or reset sequencing can quiesce one branch of the switch.
- Write data and responses pass through unmodified.

Parameters:
- BUS_CONFIG, '0, pzcorebus_config of both interfaces.
- MAX_OUTSTANDING, 8, maximum number of in-flight non-posted requests; legal range 1..255.
- COUNTER_WIDTH, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous reset, active-high.
- i_drain  input  1  level; when high, block all new commands (posted and non-posted).
- o_idle  output  1  high when the counter is 0 and no command handshake occurs this cycle.
- o_outstanding  output  COUNTER_WIDTH  current counter value (registered).
- o_underflow  output  1  sticky flag: a final response arrived while the counter was 0.
- slave_if  pzcorebus_if.slave  -  upstream side, from the switch master port.
- master_if  pzcorebus_if.master  -  downstream side, to the target.

Behaviour:
- All payload fields (mcmd, mid, maddr, mlength, minfo, mdata*, sresp*, sid, serror, sdata, sinfo) connect straight through. The block adds no cycles of latency.
- block = i_drain | (is_non_posted_command(slave_if.mcmd) & (count == MAX_OUTSTANDING)).
- master_if.mcmd_valid = slave_if.mcmd_valid & !block.
- slave_if.scmd_accept = master_if.scmd_accept & !block.
- Posted commands are never limited by the count; they are blocked only by i_drain.
- Blocking applies to the command channel only. Data beats of an already-accepted write continue to flow.
- block is a function of the registered count and i_drain only. There is no combinational path from sresp_valid/mresp_accept to the command channel.
- Command handshake (cmd_hs): slave_if.mcmd_valid & slave_if.scmd_accept & is_non_posted_command(mcmd).
- Final response handshake (resp_hs): master_if.sresp_valid & master_if.mresp_accept & sresp_last[0].
  - For the CSR profile every response beat is final.
- Counter update each cycle:
  - cmd_hs only: +1.
  - resp_hs only: -1.
  - both: unchanged.
  - neither: unchanged.
- Saturation and underflow:
  - The count cannot exceed MAX_OUTSTANDING, because cmd_hs is impossible while count == MAX.
  - resp_hs with count == 0: the counter stays 0 and o_underflow is set to 1.
  - o_underflow clears only on reset.
- Count at MAX with a final response in the same cycle: the command remains blocked this cycle and is accepted the next cycle (count == MAX-1).
- i_drain:
  - Rising while a command is valid but not yet accepted: the command is held. mcmd_valid to downstream drops, which is allowed because the handshake has not completed.
  - Upstream keeps valid asserted per protocol.
  - o_idle asserts once all responses have returned.
- o_idle = (count == 0) & !cmd_hs. It is combinational from the registered count.
- Reset values (i_rst high at a clock edge): count = 0, o_outstanding = 0, o_underflow = 0.
  - Pass-through outputs follow their inputs; mcmd_valid is gated by block, which is computed with count = 0.
- Reset mid-operation: the count is discarded. Responses that arrive after reset for pre-reset requests set o_underflow. This is the documented intended behaviour.
- State: a single counter plus the sticky flag. There is no FSM beyond this.

Test Plan:
1. MAX_OUTSTANDING=2. Issue 3 back-to-back reads with the slave never responding -> first 2 accepted, third held with scmd_accept=0, o_outstanding=2.
2. Continue from test 1: return one final response in the cycle the third read is presented -> third read stays blocked that cycle and is accepted the next cycle; o_outstanding goes 2 -> 1 -> 2.
3. At count=MAX, issue 4 posted writes with 4 data beats each -> all commands and data pass with zero added latency; o_outstanding unchanged.
4. Read command handshake and final response handshake in the same cycle with count=1 -> o_outstanding stays 1. A memory-profile response with sresp_last[0]=0 -> no decrement.
5. Assert i_drain with 3 reads outstanding, then return 3 responses -> no new commands accepted; o_idle=0 until the third final response; o_idle=1 the following cycle.
6. With count=0, inject an unsolicited final response -> o_underflow=1, o_outstanding=0. Then assert i_rst for 1 cycle -> o_underflow=0.
